// File: rtl/rv_multicycle_ctrl_if.sv
// Control-path bundle between the multicycle RV32I sequencer and its datapath/memory port.
// Memory handshake: mem_req is the valid and mem_ready the ready. An access completes on the
// single cycle where both are 1. mem_req, mem_we and mem_addr_sel stay stable until completion,
// and mem_ready is a don't-care whenever mem_req is 0.
interface rv_multicycle_ctrl_if #(
   parameter int CNT_WIDTH = 32
);
   logic [31:0]          instruction;
   logic                 branch_cond;
   logic                 mem_ready;
   logic                 mem_req;
   logic                 mem_we;
   logic                 mem_addr_sel;
   logic                 ir_write;
   logic                 pc_write;
   logic [1:0]           pc_src;
   logic                 alu_src;
   logic                 reg_write;
   logic [1:0]           wb_sel;
   logic                 csr_we;
   logic                 instr_retired;
   logic [CNT_WIDTH-1:0] instret;
   logic                 trap;
   logic [1:0]           trap_cause;
   logic [2:0]           state;

   modport master (
      input  instruction, branch_cond, mem_ready,
      output mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src,
             reg_write, wb_sel, csr_we, instr_retired, instret, trap, trap_cause, state
   );

   modport slave (
      output instruction, branch_cond, mem_ready,
      input  mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src,
             reg_write, wb_sel, csr_we, instr_retired, instret, trap, trap_cause, state
   );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over one shared memory port,
// with illegal-instruction and bus-timeout traps and a retired-instruction counter.
module rv_multicycle_ctrl #(
   parameter bit SUPPORT_CSR = 1'b1,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   rv_multicycle_ctrl_if.master bus
);

   localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   state_t               r_state;
   logic [WAIT_W-1:0]    r_wait_cnt;
   logic [CNT_WIDTH-1:0] r_instret;
   logic [1:0]           r_trap_cause;

   state_t      w_next_state;
   logic [1:0]  w_next_cause;
   logic        w_mem_req;
   logic        w_mem_we;
   logic        w_addr_sel;
   logic        w_ir_write;
   logic        w_pc_write;
   logic [1:0]  w_pc_src;
   logic        w_reg_write;
   logic        w_csr_we;
   logic        w_retire;

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic        w_rd_nz;
   logic        w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_is_branch;
   logic        w_is_load, w_is_store, w_is_opimm, w_is_op, w_is_csr;
   logic        w_legal;
   logic        w_alu_imm;
   logic [1:0]  w_wb_code;
   logic        w_in_body;
   logic        w_timeout;
   logic        w_wait_inc;
   logic        w_wait_clr;
   logic        w_unused_bits;

   assign w_opcode      = bus.instruction[6:0];
   assign w_funct3      = bus.instruction[14:12];
   assign w_rd_nz       = |bus.instruction[11:7];
   assign w_unused_bits = &{1'b0, bus.instruction[31:15]};

   assign w_is_lui    = (w_opcode == OP_LUI);
   assign w_is_auipc  = (w_opcode == OP_AUIPC);
   assign w_is_jal    = (w_opcode == OP_JAL);
   assign w_is_jalr   = (w_opcode == OP_JALR);
   assign w_is_branch = (w_opcode == OP_BRANCH);
   assign w_is_load   = (w_opcode == OP_LOAD);
   assign w_is_store  = (w_opcode == OP_STORE);
   assign w_is_opimm  = (w_opcode == OP_IMM);
   assign w_is_op     = (w_opcode == OP_OP);
   // funct3==0 under SYSTEM is ECALL/EBREAK/xRET, which this core traps on
   assign w_is_csr    = SUPPORT_CSR && (w_opcode == OP_SYSTEM) && (w_funct3 != 3'd0);

   assign w_legal = w_is_lui | w_is_auipc | w_is_jal | w_is_jalr | w_is_branch |
                    w_is_load | w_is_store | w_is_opimm | w_is_op | w_is_csr;

   assign w_alu_imm = w_is_opimm | w_is_load | w_is_store | w_is_jalr | w_is_lui | w_is_auipc;
   assign w_wb_code = w_is_load             ? 2'd1 :
                      (w_is_jal | w_is_jalr) ? 2'd2 :
                      w_is_csr              ? 2'd3 : 2'd0;

   assign w_in_body = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                      (r_state == S_MEM)    || (r_state == S_WB);

   assign w_timeout  = (MEM_TIMEOUT > 0) && !bus.mem_ready && (r_wait_cnt == WAIT_LAST);
   assign w_wait_inc = (MEM_TIMEOUT > 0) && !bus.mem_ready &&
                       ((r_state == S_FETCH) || (r_state == S_MEM));
   assign w_wait_clr = (w_next_state != r_state);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_FETCH;
         r_wait_cnt   <= '0;
         r_instret    <= '0;
         r_trap_cause <= 2'd0;
      end else begin
         r_state <= w_next_state;
         if (w_wait_clr) begin
            r_wait_cnt <= '0;
         end else if (w_wait_inc) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
         if (w_retire) begin
            r_instret <= r_instret + 1'b1;
         end
         if ((r_state != S_TRAP) && (w_next_state == S_TRAP)) begin
            r_trap_cause <= w_next_cause;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_cause = 2'd0;
      w_mem_req    = 1'b0;
      w_mem_we     = 1'b0;
      w_addr_sel   = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_pc_src     = 2'd0;
      w_reg_write  = 1'b0;
      w_csr_we     = 1'b0;
      w_retire     = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_req = 1'b1;
            if (bus.mem_ready) begin
               w_ir_write   = 1'b1;
               w_next_state = S_DECODE;
            end else if (w_timeout) begin
               w_next_state = S_TRAP;
               w_next_cause = 2'd2;
            end
         end
         S_DECODE: begin
            if (w_legal) begin
               w_next_state = S_EXEC;
            end else begin
               w_next_state = S_TRAP;
               w_next_cause = 2'd1;
            end
         end
         S_EXEC: begin
            if (w_is_branch) begin
               w_pc_write   = 1'b1;
               w_pc_src     = bus.branch_cond ? 2'd1 : 2'd0;
               w_retire     = 1'b1;
               w_next_state = S_FETCH;
            end else if (w_is_load || w_is_store) begin
               w_next_state = S_MEM;
            end else begin
               w_next_state = S_WB;
            end
         end
         S_MEM: begin
            w_mem_req  = 1'b1;
            w_addr_sel = 1'b1;
            w_mem_we   = w_is_store;
            if (bus.mem_ready) begin
               if (w_is_store) begin
                  w_pc_write   = 1'b1;
                  w_retire     = 1'b1;
                  w_next_state = S_FETCH;
               end else begin
                  w_next_state = S_WB;
               end
            end else if (w_timeout) begin
               w_next_state = S_TRAP;
               w_next_cause = 2'd2;
            end
         end
         S_WB: begin
            w_reg_write  = w_rd_nz;
            w_csr_we     = w_is_csr;
            w_pc_write   = 1'b1;
            w_pc_src     = w_is_jal ? 2'd1 : (w_is_jalr ? 2'd2 : 2'd0);
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
         end
         S_TRAP: begin
            w_next_state = S_TRAP;
         end
         default: begin
            w_next_state = S_FETCH;
         end
      endcase
   end

   // Enables are masked during the reset cycle so an interrupted access commits nothing
   assign bus.mem_req       = w_mem_req;
   assign bus.mem_addr_sel  = w_addr_sel;
   assign bus.mem_we        = w_mem_we & ~rst;
   assign bus.ir_write      = w_ir_write & ~rst;
   assign bus.pc_write      = w_pc_write & ~rst;
   assign bus.pc_src        = w_pc_src;
   assign bus.reg_write     = w_reg_write & ~rst;
   assign bus.csr_we        = w_csr_we & ~rst;
   assign bus.instr_retired = w_retire & ~rst;
   assign bus.alu_src       = w_in_body & w_alu_imm;
   assign bus.wb_sel        = w_in_body ? w_wb_code : 2'd0;
   assign bus.instret       = r_instret;
   assign bus.trap          = (r_state == S_TRAP);
   assign bus.trap_cause    = r_trap_cause;
   assign bus.state         = r_state;

endmodule
